// File: rtl/pool_kxk_band.sv
// Streaming KxK pooling over one band of K rows x (OUT_W*K) columns.
// Samples arrive in raster order; one registered result word is produced per band.
module pool_kxk_band #(
    parameter int DW    = 8,
    parameter int OUT_W = 3,
    parameter int K     = 2,
    parameter int MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic signed [DW-1:0]  in_data,
    input  logic                  in_clr,
    output logic                  out_vld,
    output logic [OUT_W*DW-1:0]   out_data,
    output logic                  busy
);

    localparam int LK   = $clog2(K);
    localparam int AW   = DW + 2 * LK;
    localparam int NCOL = OUT_W * K;
    localparam int CW   = $clog2(NCOL) + 1;
    localparam int RW   = $clog2(K) + 1;
    localparam int SH   = (MODE == 1) ? 2 * LK : 0;

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic signed [AW-1:0]  acc_q [OUT_W];
    logic signed [AW-1:0]  acc_d [OUT_W];
    logic [OUT_W*DW-1:0]   out_data_q;
    logic [OUT_W*DW-1:0]   res_d;
    logic                  out_vld_q;

    logic [CW-1:0]         win;
    logic [CW-1:0]         off;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic signed [AW-1:0]  samp_ext;

    assign accept   = in_vld & ~in_clr;
    assign win      = col_q / CW'(K);
    assign off      = col_q % CW'(K);
    assign last_col = (col_q == CW'(NCOL - 1));
    assign last_row = (row_q == RW'(K - 1));
    assign samp_ext = {{(AW-DW){in_data[DW-1]}}, in_data};

    // The first sample of each window loads; later ones fold in by max or sum.
    always_comb begin
        for (int j = 0; j < OUT_W; j++) begin
            acc_d[j] = acc_q[j];
            if (accept && (win == CW'(j))) begin
                if ((row_q == '0) && (off == '0)) begin
                    acc_d[j] = samp_ext;
                end else if (MODE == 1) begin
                    acc_d[j] = acc_q[j] + samp_ext;
                end else if (samp_ext > acc_q[j]) begin
                    acc_d[j] = samp_ext;
                end
            end
        end
    end

    // Results are taken from acc_d so the band's final sample is included.
    always_comb begin
        res_d = '0;
        for (int j = 0; j < OUT_W; j++) begin
            res_d[j*DW +: DW] = DW'(acc_d[j] >>> SH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            for (int j = 0; j < OUT_W; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            out_vld_q <= 1'b0;
            if (in_clr) begin
                col_q <= '0;
                row_q <= '0;
            end else if (in_vld) begin
                acc_q <= acc_d;
                if (last_col) begin
                    col_q <= '0;
                    if (last_row) begin
                        row_q      <= '0;
                        out_data_q <= res_d;
                        out_vld_q  <= 1'b1;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign busy     = (row_q != '0) || (col_q != '0);

endmodule

// File: tb/tb_pool_kxk_band.sv
// Bench for pool_kxk_band: three instances (max K=2, avg K=2, max K=4) share one
// input stream; a band-level model predicts each result and the monitor checks it.
module tb_pool_kxk_band;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_clr = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        ov0, ov1, ov2;
    logic        b0, b1, b2;
    logic [23:0] od0, od1;
    logic [15:0] od2;

    always #5 clk = ~clk;

    pool_kxk_band #(.DW(8), .OUT_W(3), .K(2), .MODE(0)) u_max (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_clr(in_clr),
        .out_vld(ov0), .out_data(od0), .busy(b0)
    );
    pool_kxk_band #(.DW(8), .OUT_W(3), .K(2), .MODE(1)) u_avg (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_clr(in_clr),
        .out_vld(ov1), .out_data(od1), .busy(b1)
    );
    pool_kxk_band #(.DW(8), .OUT_W(2), .K(4), .MODE(0)) u_k4 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_clr(in_clr),
        .out_vld(ov2), .out_data(od2), .busy(b2)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          cnt [3];
    int          bnd [3][32];
    logic [23:0] hold [3];
    int          pulses [3];
    int          last_t [3];
    int          prev_t [3];
    logic [23:0] exp0_q [$];
    logic [23:0] exp1_q [$];
    logic [23:0] exp2_q [$];
    int          t0_q [$];
    int          t1_q [$];
    int          t2_q [$];
    logic [23:0] e_v;

    function automatic int ow(input int d);
        return (d == 2) ? 2 : 3;
    endfunction
    function automatic int kd(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    // Pool a completed band straight from its sample list.
    function automatic logic [23:0] pool_band(input int d);
        logic [23:0] r;
        int k, w, s, m, v, q;
        r = '0;
        k = kd(d);
        w = ow(d);
        for (int j = 0; j < w; j++) begin
            s = 0;
            m = -1000;
            for (int rr = 0; rr < k; rr++) begin
                for (int cc = 0; cc < k; cc++) begin
                    v = bnd[d][rr * w * k + j * k + cc];
                    s += v;
                    if (v > m) m = v;
                end
            end
            if (d == 1) begin
                q = s / (k * k);
                if (((s % (k * k)) != 0) && (s < 0)) q -= 1;
            end else begin
                q = m;
            end
            r[j*8 +: 8] = q[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d actual=%h expected=%h (cycle %0d)", nm, d, got, exp, cyc);
        end
    endtask

    // Reference model: counts accepted samples per instance.
    initial begin
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0; hold[d] = '0; pulses[d] = 0; last_t[d] = 0; prev_t[d] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 3; d++) begin
                    cnt[d] = 0;
                    hold[d] = '0;
                end
            end else begin
                cyc++;
                for (int d = 0; d < 3; d++) begin
                    if (in_clr) begin
                        cnt[d] = 0;
                    end else if (in_vld) begin
                        bnd[d][cnt[d]] = int'($signed(in_data));
                        cnt[d]++;
                        if (cnt[d] == kd(d) * kd(d) * ow(d)) begin
                            e_v = pool_band(d);
                            hold[d] = e_v;
                            cnt[d] = 0;
                            case (d)
                                0: begin exp0_q.push_back(e_v); t0_q.push_back(cyc); end
                                1: begin exp1_q.push_back(e_v); t1_q.push_back(cyc); end
                                default: begin exp2_q.push_back(e_v); t2_q.push_back(cyc); end
                            endcase
                        end
                    end
                end
            end
        end
    end

    // Monitor: busy, held output and every pulse against the model.
    initial begin
        logic        mv, mb;
        logic [23:0] mo, me;
        int          mt, qn;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                case (d)
                    0: begin mv = ov0; mo = od0; mb = b0; qn = exp0_q.size(); end
                    1: begin mv = ov1; mo = od1; mb = b1; qn = exp1_q.size(); end
                    default: begin mv = ov2; mo = {8'h00, od2}; mb = b2; qn = exp2_q.size(); end
                endcase
                chk("busy", d, 32'(mb), 32'(rst_n && (cnt[d] != 0)));
                chk("out_hold", d, 32'(mo), rst_n ? 32'(hold[d]) : 32'h0);
                if (mv) begin
                    pulses[d]++;
                    prev_t[d] = last_t[d];
                    last_t[d] = cyc;
                    tests++;
                    if (qn == 0) begin
                        fails++;
                        $display("FAIL unexpected_pulse dut%0d actual=pulse expected=none (cycle %0d)", d, cyc);
                    end else begin
                        case (d)
                            0: begin me = exp0_q.pop_front(); mt = t0_q.pop_front(); end
                            1: begin me = exp1_q.pop_front(); mt = t1_q.pop_front(); end
                            default: begin me = exp2_q.pop_front(); mt = t2_q.pop_front(); end
                        endcase
                        chk("pulse_data", d, 32'(mo), 32'(me));
                        chk("pulse_cycle", d, 32'(cyc), 32'(mt));
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] dat, input logic c);
        @(posedge clk);
        #1;
        in_vld  = v;
        in_data = dat;
        in_clr  = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    function automatic logic [7:0] rnd_sample();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h80;
        if (r == 1) return 8'h7F;
        return 8'($urandom_range(0, 255));
    endfunction

    logic [7:0] pat029 [12];
    logic [7:0] pat031 [12];
    int         p;

    initial begin
        pat029 = '{8'h01, 8'h05, 8'hFD, 8'hF9, 8'h64, 8'h02,
                   8'h04, 8'hFE, 8'hF8, 8'hFF, 8'h80, 8'h7F};
        pat031 = '{8'hFF, 8'hFE, 8'h7F, 8'h7F, 8'h80, 8'h80,
                   8'hFD, 8'hFC, 8'h7F, 8'h7F, 8'h80, 8'h80};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 0, 32'(od0), 32'h0);
        chk("reset_vld", 2, 32'(ov2), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Continuous band of known data
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, pat029[i], 1'b0);
        idle(3);
        chk("band_cont", 0, 32'(od0), 32'h7FFF05);

        // Same data with 3-cycle gaps
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, pat029[i], 1'b0);
            idle(3);
        end
        chk("band_gaps", 0, 32'(od0), 32'h7FFF05);

        // Averaging: negative floor and saturated window
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, pat031[i], 1'b0);
        idle(3);
        chk("avg_band", 1, 32'(od1), 32'h807FFD);

        // Aborted band, then all -5
        drive(1'b0, 8'h00, 1'b1);
        p = pulses[0];
        for (int i = 0; i < 7; i++) drive(1'b1, rnd_sample(), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, 8'hFB, 1'b0);
        idle(3);
        chk("clr_pulses", 0, 32'(pulses[0]), 32'(p + 1));
        chk("clr_data", 0, 32'(od0), 32'hFBFBFB);
        drive(1'b0, 8'h00, 1'b1);
        p = pulses[0];
        for (int i = 0; i < 11; i++) drive(1'b1, rnd_sample(), 1'b0);
        drive(1'b1, rnd_sample(), 1'b1);
        idle(3);
        chk("clr_final", 0, 32'(pulses[0]), 32'(p));

        // Reset mid-band
        for (int i = 0; i < 4; i++) drive(1'b1, rnd_sample(), 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle(3);
        chk("rst_mid_out", 0, 32'(od0), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, pat029[i], 1'b0);
        idle(3);
        chk("rst_mid_band", 0, 32'(od0), 32'h7FFF05);

        // Back-to-back K=4 bands
        drive(1'b0, 8'h00, 1'b1);
        p = pulses[2];
        for (int i = 0; i < 64; i++) drive(1'b1, rnd_sample(), 1'b0);
        idle(3);
        chk("b2b_pulses", 2, 32'(pulses[2]), 32'(p + 2));
        chk("b2b_spacing", 2, 32'(last_t[2] - prev_t[2]), 32'd32);

        // Random traffic with occasional clears and one reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                idle(2);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rnd_sample(),
                  ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end
        idle(5);
        chk("drain", 0, 32'(exp0_q.size()), 32'h0);
        chk("drain", 1, 32'(exp1_q.size()), 32'h0);
        chk("drain", 2, 32'(exp2_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pool_kxk_band.md
POOL_KXK_BAND -- requirements
Module: pool_kxk_band

Interface
REQ-001 Parameter DW, default 8: signed input/output sample width, two's complement.
REQ-002 Parameter OUT_W, default 3: pooled output columns per band.
REQ-003 Parameter K, default 2: pooling window edge; legal range 2..4.
REQ-004 Parameter MODE, default 0: 0 = max pooling, 1 = average pooling; MODE=1 legal only for K in {2,4}.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_vld  input  1  in_data valid this cycle; sample accepted at the rising edge where in_vld=1 and in_clr=0.
REQ-008 in_data  input  DW  signed conv sample; raster order within a band of K rows x (OUT_W*K) columns.
REQ-009 in_clr  input  1  synchronous band restart; zeroes counters, discards partial band.
REQ-010 out_vld  output  1  single-cycle pulse: out_data holds a newly completed band.
REQ-011 out_data  output  OUT_W*DW  pooled results; column j at bits [j*DW +: DW], raw two's-complement bits.
REQ-012 busy  output  1  high while a band is partially accepted (>=1 sample, not complete).

Function
REQ-013 Internal counters: col (0..OUT_W*K-1), row (0..K-1); win = col / K, off = col % K.
REQ-014 Each accepted sample advances col; col at OUT_W*K-1 wraps to 0 and row advances; row at K-1 with col wrap ends the band and both counters return to 0.
REQ-015 One accumulator per output column; accumulator win is loaded (not combined) when row=0 and off=0.
REQ-016 Max mode: any other accepted sample updates accumulator win to the signed max of stored value and in_data; equal values leave it unchanged.
REQ-017 Avg mode: accumulator width DW+2*log2(K); signed sum of all K*K samples with no intermediate overflow; result = sum arithmetic-shifted right by 2*log2(K) (floor toward -inf), truncated to DW bits.
REQ-018 Band completion: on the edge accepting the final sample (row=K-1, col=OUT_W*K-1), out_data is registered with all OUT_W results, including the final sample's own contribution, and out_vld=1 for exactly the following cycle.
REQ-019 Latency: one clock from final-sample acceptance to out_vld/out_data visible; no combinational path from in_data to out_data.
REQ-020 out_data holds its value until the next band completes; it is unaffected by in_clr or partial bands.
REQ-021 in_vld=0 cycles: counters and accumulators hold; gaps of any length within a band are legal.
REQ-022 in_clr=1: counters to 0, busy to 0 next cycle; accumulators need not be cleared (next load overwrites); a coincident in_vld sample is discarded; clr wins.
REQ-023 in_clr on the cycle a final sample is presented: sample discarded, no out_vld.
REQ-024 Back-to-back bands: the first sample of band n+1 may be accepted in the cycle out_vld for band n is high; no bubble required.
REQ-025 busy = (row!=0 or col!=0), registered-state derived.

Reset
REQ-026 rst_n=0 asynchronously clears: col, row, all accumulators, out_data to 0, out_vld to 0, busy to 0.
REQ-027 Reset asserted mid-band abandons the band; first accepted sample after release is row 0, col 0.
REQ-028 No output pulses during reset or in the first cycle after release unless a full band has been accepted.

Verification
REQ-029 Defaults (DW=8,OUT_W=3,K=2,MODE=0), band rows [1,5,-3,-7,100,2] and [4,-2,-8,-1,-128,127] continuous -> one out_vld pulse, out_data columns {5,-1,127}.
REQ-030 Same data with in_vld gaps of 3 cycles between every sample -> identical out_data, out_vld exactly one cycle after final-sample edge, busy high from first sample until completion.
REQ-031 MODE=1, K=2, column-0 window {-1,-2,-3,-4} (sum -10) -> column-0 result -3 (0xFD); window {127,127,127,127} -> 127, no overflow.
REQ-032 in_clr after 7 samples, then full new band of all -5 -> single out_vld, all columns -5; no pulse for the aborted band; in_clr with in_vld on final sample -> no pulse.
REQ-033 rst_n pulsed low mid-band (after 4 samples), then full band -> out_data 0 during reset, correct results for new band only.
REQ-034 Two bands back-to-back with no idle cycle, K=4, OUT_W=2 -> two out_vld pulses exactly 32 cycles apart, each band's maxima correct.
